hps_reset_req_ctrl: RTL and testbench

//  Generates the HPS FPGA-to-HPS reset requests: cold, warm and debug.

---
 rtl/hps_reset_req_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hps_reset_req_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_reset_req_ctrl.sv
// HPS FPGA-to-HPS reset request generator.
// Asynchronous pushbutton/supervisor lines are synchronised, debounced and
// mapped to a reset kind (cold/warm/debug). Software pulses join them as
// pending requests. One request at a time is issued as a fixed-width
// active-low pulse, followed by a quiet holdoff window.
//
// Request acceptance: there is no valid/ready handshake on the inputs.
// A source event or an sw_req bit is latched into its pending flag on the
// clock edge where it is seen. It is held until a pulse of that kind starts,
// or until a cold pulse starts (which consumes everything). It is discarded
// if req_enable is low on that edge. A started pulse always runs to the end
// of its holdoff window.
module hps_reset_req_ctrl #(
  parameter int unsigned          NUM_SRC         = 4,
  parameter logic [2*NUM_SRC-1:0] SRC_KIND        = 8'b11_10_01_00,
  parameter int unsigned          DEBOUNCE_CYCLES = 8,
  parameter int unsigned          PULSE_CYCLES    = 16,
  parameter int unsigned          HOLDOFF_CYCLES  = 64
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_SRC-1:0] src_req_n,
  input  logic [2:0]         sw_req,
  input  logic               req_enable,
  output logic               hps_0_f2h_cold_reset_req_reset_n,
  output logic               hps_0_f2h_warm_reset_req_reset_n,
  output logic               hps_0_f2h_debug_reset_req_reset_n,
  output logic               busy,
  output logic [1:0]         last_kind,
  output logic [7:0]         req_count,
  output logic [1:0]         o_dbg_state
);

  // Reset kinds; the index also selects the bit in the 3-bit request vectors.
  localparam logic [1:0] KIND_COLD  = 2'd0;
  localparam logic [1:0] KIND_WARM  = 2'd1;
  localparam logic [1:0] KIND_DEBUG = 2'd2;
  localparam logic [1:0] KIND_NONE  = 2'd3;

  // FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // One shared timer serves both the pulse and the holdoff phase.
  localparam int unsigned TIM_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TIM_W   = $clog2(TIM_MAX + 1);
  localparam logic [TIM_W-1:0] PULSE_LAST   = TIM_W'(PULSE_CYCLES - 1);
  localparam logic [TIM_W-1:0] HOLDOFF_LAST = TIM_W'(HOLDOFF_CYCLES - 1);

  // Source path state.
  logic [NUM_SRC-1:0]           r_sync1;
  logic [NUM_SRC-1:0]           r_sync2;
  logic [NUM_SRC-1:0][DB_W-1:0] r_db_cnt;
  logic [NUM_SRC-1:0]           r_pressed;
  logic [NUM_SRC-1:0]           r_pressed_q;
  logic [NUM_SRC-1:0]           w_src_rise;
  logic [2:0]                   w_src_kind_evt;

  // Request arbitration.
  logic [2:0] w_req_set;
  logic [2:0] r_pend;
  logic [2:0] w_pend_clr;
  logic [1:0] w_sel_kind;
  logic [2:0] w_sel_oh;
  logic       w_start;

  // Pulse generator.
  logic [1:0]       r_state;
  logic [TIM_W-1:0] r_tim;
  logic [2:0]       r_req_n;
  logic [1:0]       r_last_kind;
  logic [7:0]       r_req_count;

  // Two-flop synchroniser; preset to the released (high) level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= src_req_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the pressed state flips only after DEBOUNCE_CYCLES consecutive
  // synced samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_db_cnt    <= '0;
      r_pressed   <= '0;
      r_pressed_q <= '0;
    end else begin
      r_pressed_q <= r_pressed;
      for (int i = 0; i < NUM_SRC; i++) begin
        // A low synced line means "pressed", so agreement is sync2 != pressed.
        if (r_sync2[i] != r_pressed[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i]  <= '0;
          r_pressed[i] <= ~r_pressed[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A new press is the rising edge of the debounced state; a held line
  // yields exactly one event until it has been released and debounced.
  assign w_src_rise = r_pressed & ~r_pressed_q;

  // Map each line's press event onto its configured reset kind.
  always_comb begin
    w_src_kind_evt = 3'b000;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_src_rise[i]) begin
        case (SRC_KIND[2*i +: 2])
          KIND_COLD:  w_src_kind_evt[0] = 1'b1;
          KIND_WARM:  w_src_kind_evt[1] = 1'b1;
          KIND_DEBUG: w_src_kind_evt[2] = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // Software and source requests of the same kind merge into one flag.
  assign w_req_set = w_src_kind_evt | sw_req;

  // Fixed priority cold > warm > debug over the pending flags.
  always_comb begin
    w_sel_kind = KIND_DEBUG;
    w_sel_oh   = 3'b100;
    if (r_pend[0]) begin
      w_sel_kind = KIND_COLD;
      w_sel_oh   = 3'b001;
    end else if (r_pend[1]) begin
      w_sel_kind = KIND_WARM;
      w_sel_oh   = 3'b010;
    end
  end

  assign w_start = (r_state == ST_IDLE) && req_enable && (|r_pend);

  // A cold reset supersedes everything queued behind it.
  assign w_pend_clr = !w_start    ? 3'b000 :
                      w_sel_oh[0] ? 3'b111 : w_sel_oh;

  // Pending flags: set in any state, consumed at pulse start, flushed while disabled.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pend <= '0;
    end else if (!req_enable) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | w_req_set;
    end
  end

  // IDLE -> PULSE -> HOLDOFF -> IDLE with registered active-low outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_tim       <= '0;
      r_req_n     <= 3'b111;
      r_last_kind <= KIND_NONE;
      r_req_count <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_n <= 3'b111;
          r_tim   <= '0;
          if (w_start) begin
            r_state     <= ST_PULSE;
            r_req_n     <= ~w_sel_oh;
            r_last_kind <= w_sel_kind;
            if (r_req_count != 8'hFF) begin
              r_req_count <= r_req_count + 8'd1;
            end
          end
        end
        ST_PULSE: begin
          if (r_tim == PULSE_LAST) begin
            r_state <= ST_HOLDOFF;
            r_tim   <= '0;
            r_req_n <= 3'b111;
          end else begin
            r_tim <= r_tim + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          r_req_n <= 3'b111;
          if (r_tim == HOLDOFF_LAST) begin
            r_state <= ST_IDLE;
            r_tim   <= '0;
          end else begin
            r_tim <= r_tim + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tim   <= '0;
          r_req_n <= 3'b111;
        end
      endcase
    end
  end

  assign hps_0_f2h_cold_reset_req_reset_n  = r_req_n[0];
  assign hps_0_f2h_warm_reset_req_reset_n  = r_req_n[1];
  assign hps_0_f2h_debug_reset_req_reset_n = r_req_n[2];
  assign busy        = (r_state != ST_IDLE);
  assign last_kind   = r_last_kind;
  assign req_count   = r_req_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hps_reset_req_ctrl.sv
// Bench for hps_reset_req_ctrl: directed scenarios followed by a randomised
// run, all checked every cycle against a timestamp-based reference model.
module tb_hps_reset_req_ctrl;

  localparam int D = 8;
  localparam int P = 16;
  localparam int H = 64;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] src_n = 4'hF;
  logic [2:0] sw    = 3'b000;
  logic       en    = 1'b1;

  wire        cold_n;
  wire        warm_n;
  wire        debug_n;
  wire        busy;
  wire [1:0]  last_kind;
  wire [7:0]  req_count;
  wire [1:0]  dbg_state;

  always #5 clk = ~clk;

  hps_reset_req_ctrl dut (
    .clk_clk                           (clk),
    .reset_reset_n                     (rst_n),
    .src_req_n                         (src_n),
    .sw_req                            (sw),
    .req_enable                        (en),
    .hps_0_f2h_cold_reset_req_reset_n  (cold_n),
    .hps_0_f2h_warm_reset_req_reset_n  (warm_n),
    .hps_0_f2h_debug_reset_req_reset_n (debug_n),
    .busy                              (busy),
    .last_kind                         (last_kind),
    .req_count                         (req_count),
    .o_dbg_state                       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // Reference model: pulses are described by their start edge and kind.
  int         m_edge;
  logic [2:0] m_pend;
  int         m_start;
  int         m_kind;
  int         m_next_ok;
  int         m_count;
  int         m_last;
  int         low_run  [4];
  int         high_run [4];
  bit         m_pressed[4];
  int         src_kind [4] = '{0, 1, 2, 3};
  int         ev_t[$];
  int         ev_k[$];

  // Observations of the DUT outputs, compared with spec constants.
  int obs_low_cnt[3];
  int obs_first  [3];
  int obs_busy_first;
  int obs_busy_last;

  int k;
  int src_hold[4];
  int en_hold;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  task automatic model_reset();
    m_edge    = 0;
    m_pend    = 3'b000;
    m_start   = -100000;
    m_kind    = 0;
    m_next_ok = 0;
    m_count   = 0;
    m_last    = 3;
    for (int i = 0; i < 4; i++) begin
      low_run[i]   = 0;
      high_run[i]  = 1000;
      m_pressed[i] = 1'b0;
    end
    ev_t.delete();
    ev_k.delete();
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 3; i++) begin
      obs_low_cnt[i] = 0;
      obs_first[i]   = -1;
    end
    obs_busy_first = -1;
    obs_busy_last  = -1;
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    logic [2:0] newset;
    int         kk;
    m_edge++;
    newset = sw;
    while (ev_t.size() > 0 && ev_t[0] == m_edge) begin
      newset[ev_k[0]] = 1'b1;
      void'(ev_t.pop_front());
      void'(ev_k.pop_front());
    end
    // A line sampled low for D edges in a row becomes a press; its request
    // reaches the pending set three edges later (sync + debounce + edge detect).
    for (int i = 0; i < 4; i++) begin
      if (!src_n[i]) begin
        low_run[i]++;
        high_run[i] = 0;
      end else begin
        high_run[i]++;
        low_run[i] = 0;
      end
      if (!m_pressed[i] && low_run[i] == D) begin
        m_pressed[i] = 1'b1;
        if (src_kind[i] != 3) begin
          ev_t.push_back(m_edge + 3);
          ev_k.push_back(src_kind[i]);
        end
      end else if (m_pressed[i] && high_run[i] == D) begin
        m_pressed[i] = 1'b0;
      end
    end
    if (!en) begin
      m_pend = 3'b000;
    end else if (m_pend != 3'b000 && m_edge >= m_next_ok) begin
      kk        = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
      m_start   = m_edge;
      m_kind    = kk;
      m_next_ok = m_edge + P + H + 1;
      m_last    = kk;
      if (m_count < 255) m_count++;
      if (kk == 0) m_pend = 3'b000;
      else m_pend[kk] = 1'b0;
      m_pend = m_pend | newset;
    end else begin
      m_pend = m_pend | newset;
    end
  endtask

  task automatic compare_all();
    bit in_pulse;
    bit in_busy;
    in_pulse = (m_edge >= m_start) && (m_edge < m_start + P);
    in_busy  = (m_edge >= m_start) && (m_edge < m_start + P + H);
    check_eq("cold_n",    32'(cold_n),    (in_pulse && m_kind == 0) ? 0 : 1);
    check_eq("warm_n",    32'(warm_n),    (in_pulse && m_kind == 1) ? 0 : 1);
    check_eq("debug_n",   32'(debug_n),   (in_pulse && m_kind == 2) ? 0 : 1);
    check_eq("busy",      32'(busy),      in_busy ? 1 : 0);
    check_eq("last_kind", 32'(last_kind), m_last);
    check_eq("req_count", 32'(req_count), m_count);
  endtask

  task automatic observe();
    if (!cold_n)  begin if (obs_first[0] < 0) obs_first[0] = m_edge; obs_low_cnt[0]++; end
    if (!warm_n)  begin if (obs_first[1] < 0) obs_first[1] = m_edge; obs_low_cnt[1]++; end
    if (!debug_n) begin if (obs_first[2] < 0) obs_first[2] = m_edge; obs_low_cnt[2]++; end
    if (busy) begin
      if (obs_busy_first < 0) obs_busy_first = m_edge;
      obs_busy_last = m_edge;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    observe();
  endtask

  task automatic random_stim();
    sw = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    if (en_hold == 0) begin
      en      = ($urandom_range(0, 7) != 0);
      en_hold = $urandom_range(1, 60);
    end else begin
      en_hold--;
    end
    for (int i = 0; i < 4; i++) begin
      if (src_hold[i] == 0) begin
        src_n[i]    = ~src_n[i];
        src_hold[i] = src_n[i] ? $urandom_range(5, 60) : $urandom_range(1, 20);
      end else begin
        src_hold[i]--;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    clr_obs();
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_cold_n",    32'(cold_n),    1);
    check_eq("rst_warm_n",    32'(warm_n),    1);
    check_eq("rst_debug_n",   32'(debug_n),   1);
    check_eq("rst_busy",      32'(busy),      0);
    check_eq("rst_last_kind", 32'(last_kind), 3);
    check_eq("rst_req_count", 32'(req_count), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    clr_obs();

    // 1: software cold request at edge 10.
    repeat (9) cycle();
    sw = 3'b001;
    cycle();
    sw = 3'b000;
    repeat (85) cycle();
    check_eq("t1_cold_first", obs_first[0], 11);
    check_eq("t1_cold_len",   obs_low_cnt[0], 16);
    check_eq("t1_busy_first", obs_busy_first, 11);
    check_eq("t1_busy_last",  obs_busy_last, 90);
    check_eq("t1_last_kind",  32'(last_kind), 0);
    check_eq("t1_req_count",  32'(req_count), 1);

    // 2: short glitch ignored, long hold yields one warm pulse.
    clr_obs();
    src_n[1] = 1'b0;
    repeat (5) cycle();
    src_n[1] = 1'b1;
    repeat (30) cycle();
    check_eq("t2_glitch", obs_low_cnt[1] + obs_busy_first + 1, 0);
    k = m_edge + 1;
    src_n[1] = 1'b0;
    repeat (40) cycle();
    src_n[1] = 1'b1;
    repeat (100) cycle();
    check_eq("t2_warm_first", obs_first[1], k + 11);
    check_eq("t2_warm_len",   obs_low_cnt[1], 16);
    check_eq("t2_req_count",  32'(req_count), 2);

    // 3: warm and debug together -> warm first, debug after holdoff.
    clr_obs();
    k = m_edge + 1;
    sw = 3'b110;
    cycle();
    sw = 3'b000;
    repeat (180) cycle();
    check_eq("t3_warm_first",  obs_first[1], k + 1);
    check_eq("t3_debug_first", obs_first[2], k + 82);
    check_eq("t3_debug_len",   obs_low_cnt[2], 16);
    check_eq("t3_req_count",   32'(req_count), 4);
    check_eq("t3_last_kind",   32'(last_kind), 2);

    // 4: debug then cold queued during a warm pulse -> cold wipes debug.
    clr_obs();
    k = m_edge + 1;
    sw = 3'b010;
    cycle();
    sw = 3'b000;
    repeat (4) cycle();
    sw = 3'b100;
    cycle();
    sw = 3'b000;
    repeat (2) cycle();
    sw = 3'b001;
    cycle();
    sw = 3'b000;
    repeat (200) cycle();
    check_eq("t4_warm_first", obs_first[1], k + 1);
    check_eq("t4_cold_first", obs_first[0], k + 82);
    check_eq("t4_debug_cnt",  obs_low_cnt[2], 0);
    check_eq("t4_req_count",  32'(req_count), 6);

    // 6: disabled -> software and kind-3 source requests produce nothing.
    clr_obs();
    en = 1'b0;
    sw = 3'b010;
    cycle();
    sw = 3'b000;
    src_n[3] = 1'b0;
    repeat (30) cycle();
    src_n[3] = 1'b1;
    repeat (15) cycle();
    en = 1'b1;
    repeat (20) cycle();
    check_eq("t6_pulses", obs_low_cnt[0] + obs_low_cnt[1] + obs_low_cnt[2], 0);
    check_eq("t6_req_count", 32'(req_count), 6);

    // 5: asynchronous reset in the middle of a cold pulse.
    clr_obs();
    sw = 3'b001;
    cycle();
    sw = 3'b000;
    repeat (5) cycle();
    check_eq("t5_pre_cold_n", 32'(cold_n), 0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_cold_n",    32'(cold_n),    1);
    check_eq("t5_busy",      32'(busy),      0);
    check_eq("t5_last_kind", 32'(last_kind), 3);
    check_eq("t5_req_count", 32'(req_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    clr_obs();
    repeat (150) cycle();
    check_eq("t5_no_pulse", obs_low_cnt[0] + obs_low_cnt[1] + obs_low_cnt[2], 0);
    check_eq("t5_no_busy",  obs_busy_first, -1);

    // Randomised run against the model.
    en_hold = 0;
    for (int i = 0; i < 4; i++) src_hold[i] = $urandom_range(0, 30);
    repeat (5000) begin
      random_stim();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
